// File: rtl/sc_eval_sequencer.sv
// Job controller for the stochastic add/multiply datapath: serialises operands,
// gates a 2^k-cycle evaluation window, counts ones and returns a scaled result.
module sc_eval_sequencer #(
  parameter int OP_W      = 9,
  parameter int WIN_LOG2  = 17,
  parameter int GUARD_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_a,
  input  logic [OP_W-1:0] req_b,
  input  logic            req_mode,
  input  logic [1:0]      req_win_sel,
  input  logic            abort,
  output logic            ser_a,
  output logic            ser_b,
  output logic            ser_mode,
  output logic            dp_load,
  output logic            dp_run,
  input  logic            sn_bit,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [OP_W:0]   res_value,
  output logic            res_mode,
  output logic            busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid-side holds its payload stable until that edge, ready never
  // depends combinationally on valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GUARD = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int IDX_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam int GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int CNT_W = WIN_LOG2 + 1;

  state_t              state;
  logic [OP_W-1:0]     a_sh;
  logic [OP_W-1:0]     b_sh;
  logic [1:0]          win_sel_q;
  logic [IDX_W-1:0]    idx;
  logic [GRD_W-1:0]    grd_cnt;
  logic [WIN_LOG2-1:0] run_cnt;
  logic [CNT_W-1:0]    count;

  logic [CNT_W-1:0]    count_next;
  logic [CNT_W-1:0]    count_aligned;
  logic [WIN_LOG2-1:0] run_last;
  logic [OP_W:0]       scaled;

  // Aligning the count to the largest window lets one fixed slice serve every
  // win_sel; count <= 2^(WIN_LOG2-sel) so the left shift never loses bits.
  always_comb begin
    count_next    = count + CNT_W'(sn_bit);
    count_aligned = count_next << win_sel_q;
    scaled        = (OP_W+1)'(count_aligned >> (WIN_LOG2 - OP_W));
    run_last      = {WIN_LOG2{1'b1}} >> win_sel_q;
  end

  // rst_n is folded in so ready reads 0 throughout reset and 1 right after release.
  assign req_ready = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      win_sel_q <= '0;
      idx       <= '0;
      grd_cnt   <= '0;
      run_cnt   <= '0;
      count     <= '0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_mode  <= 1'b0;
      dp_load   <= 1'b0;
      dp_run    <= 1'b0;
      res_valid <= 1'b0;
      res_value <= '0;
      res_mode  <= 1'b0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_mode  <= 1'b0;
      dp_load   <= 1'b0;
      dp_run    <= 1'b0;
      res_valid <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !abort) begin
            state     <= SHIFT;
            ser_a     <= req_a[0];
            ser_b     <= req_b[0];
            a_sh      <= req_a >> 1;
            b_sh      <= req_b >> 1;
            ser_mode  <= req_mode;
            win_sel_q <= req_win_sel;
            idx       <= '0;
          end
        end
        SHIFT: begin
          if (idx == IDX_W'(OP_W - 1)) begin
            state   <= GUARD;
            ser_a   <= 1'b0;
            ser_b   <= 1'b0;
            dp_load <= 1'b1;
            grd_cnt <= '0;
          end else begin
            ser_a <= a_sh[0];
            ser_b <= b_sh[0];
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            idx   <= idx + 1'b1;
          end
        end
        GUARD: begin
          dp_load <= 1'b0;
          if (grd_cnt == GRD_W'(GUARD_CYC - 1)) begin
            state   <= RUN;
            dp_run  <= 1'b1;
            count   <= '0;
            run_cnt <= '0;
          end else begin
            grd_cnt <= grd_cnt + 1'b1;
          end
        end
        RUN: begin
          count <= count_next;
          if (run_cnt == run_last) begin
            state     <= DONE;
            dp_run    <= 1'b0;
            res_valid <= 1'b1;
            res_value <= scaled;
            res_mode  <= ser_mode;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            ser_mode  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
